// File: rtl/wb_pkg.sv
// Shared defaults and FSM state type for the register-file write-back arbiter.
// Also holds a modulo-DEPTH pointer increment helper.
package wb_pkg;

    localparam int WB_DATA_W       = 32;
    localparam int WB_ADDR_W       = 5;
    localparam int WB_DEPTH        = 2;
    localparam int WB_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FORCE = 2'd2
    } wb_state_t;

    function automatic int wrap_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending MDU-result FIFO: one-cycle push/pop, head and per-entry rd/valid visible combinationally.
// Caller guarantees no push when full and no pop when empty.
module wb_pend_fifo
    import wb_pkg::*;
#(
    parameter  int DATA_W = WB_DATA_W,
    parameter  int ADDR_W = WB_ADDR_W,
    parameter  int DEPTH  = WB_DEPTH,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_push,
    input  logic [ADDR_W-1:0]              i_push_rd,
    input  logic [DATA_W-1:0]              i_push_data,
    input  logic                           i_pop,
    output logic [CNT_W-1:0]               o_count,
    output logic [ADDR_W-1:0]              o_head_rd,
    output logic [DATA_W-1:0]              o_head_data,
    output logic [DEPTH-1:0][ADDR_W-1:0]   o_ent_rd,
    output logic [DEPTH-1:0]               o_ent_vld
);

    logic [PTR_W-1:0]              r_wptr;
    logic [PTR_W-1:0]              r_rptr;
    logic [CNT_W-1:0]              r_count;
    logic [DEPTH-1:0][ADDR_W-1:0]  r_rd;
    logic [DEPTH-1:0][DATA_W-1:0]  r_data;
    logic [DEPTH-1:0]              r_vld;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_rd    <= '0;
            r_data  <= '0;
            r_vld   <= '0;
        end else begin
            if (i_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= PTR_W'(wrap_inc(int'(r_rptr), DEPTH));
            end
            // Set after clear so a push into the slot just freed keeps its valid bit.
            if (i_push) begin
                r_rd[r_wptr]   <= i_push_rd;
                r_data[r_wptr] <= i_push_data;
                r_vld[r_wptr]  <= 1'b1;
                r_wptr         <= PTR_W'(wrap_inc(int'(r_wptr), DEPTH));
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (i_pop && !i_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_count     = r_count;
    assign o_head_rd   = r_rd[r_rptr];
    assign o_head_data = r_data[r_rptr];
    assign o_ent_rd    = r_rd;
    assign o_ent_vld   = r_vld;

endmodule

// File: rtl/wb_arbiter.sv
// Shares one register-file write port between the pipeline and a multi-cycle unit; write lands one cycle after selection.
// MDU results wait in a small FIFO (mdu_ready = not full); a result starved STARVE_LIMIT cycles stalls the pipeline once.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W       = WB_DATA_W,
    parameter int ADDR_W       = WB_ADDR_W,
    parameter int DEPTH        = WB_DEPTH,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [ADDR_W-1:0] mdu_rd,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              pipe_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] query_rd,
    output logic              query_hit
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    wb_state_t                    r_state;
    wb_state_t                    w_next;
    logic [AGE_W-1:0]             r_age;
    logic [AGE_W-1:0]             w_age_next;
    logic [AGE_W-1:0]             w_age_inc;
    logic [CNT_W-1:0]             w_count;
    logic [ADDR_W-1:0]            w_head_rd;
    logic [DATA_W-1:0]            w_head_data;
    logic [DEPTH-1:0][ADDR_W-1:0] w_ent_rd;
    logic [DEPTH-1:0]             w_ent_vld;
    logic                         w_push;
    logic                         w_enq;
    logic                         w_pop;
    logic                         w_sel_vld;
    logic [ADDR_W-1:0]            w_sel_rd;
    logic [DATA_W-1:0]            w_sel_data;
    logic                         w_last_out;

    assign mdu_ready  = (w_count < CNT_W'(DEPTH));
    assign w_push     = mdu_valid && mdu_ready;
    assign w_age_inc  = r_age + AGE_W'(1);
    assign w_last_out = (w_count == CNT_W'(1)) && !w_enq;
    assign pipe_stall = (r_state == FORCE);

    always_comb begin
        w_next     = r_state;
        w_age_next = r_age;
        w_enq      = 1'b0;
        w_pop      = 1'b0;
        w_sel_vld  = 1'b0;
        w_sel_rd   = '0;
        w_sel_data = '0;
        unique case (r_state)
            IDLE: begin
                w_age_next = '0;
                if (pipe_we) begin
                    w_sel_vld  = 1'b1;
                    w_sel_rd   = pipe_rd;
                    w_sel_data = pipe_data;
                    w_enq      = w_push;
                    if (w_push) w_next = DRAIN;
                end else if (w_push) begin
                    // Port is free: MDU result goes straight to the register file.
                    w_sel_vld  = 1'b1;
                    w_sel_rd   = mdu_rd;
                    w_sel_data = mdu_data;
                end
            end
            DRAIN: begin
                w_enq = w_push;
                if (pipe_we && (pipe_rd != '0)) begin
                    w_sel_vld  = 1'b1;
                    w_sel_rd   = pipe_rd;
                    w_sel_data = pipe_data;
                    w_age_next = w_age_inc;
                    if (w_age_inc >= AGE_W'(STARVE_LIMIT)) w_next = FORCE;
                end else begin
                    w_pop      = 1'b1;
                    w_sel_vld  = 1'b1;
                    w_sel_rd   = w_head_rd;
                    w_sel_data = w_head_data;
                    w_age_next = '0;
                    if (w_last_out) w_next = IDLE;
                end
            end
            FORCE: begin
                w_enq      = w_push;
                w_pop      = 1'b1;
                w_sel_vld  = 1'b1;
                w_sel_rd   = w_head_rd;
                w_sel_data = w_head_data;
                w_age_next = '0;
                w_next     = w_last_out ? IDLE : DRAIN;
            end
            default: begin
                w_next     = IDLE;
                w_age_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_age    <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            r_state <= w_next;
            r_age   <= w_age_next;
            rf_we   <= w_sel_vld && (w_sel_rd != '0);
            if (w_sel_vld) begin
                rf_waddr <= w_sel_rd;
                rf_wdata <= w_sel_data;
            end
        end
    end

    always_comb begin
        query_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_vld[i] && (w_ent_rd[i] == query_rd)) query_hit = 1'b1;
        end
        if (query_rd == '0) query_hit = 1'b0;
    end

    wb_pend_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_push      (w_enq),
        .i_push_rd   (mdu_rd),
        .i_push_data (mdu_data),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data),
        .o_ent_rd    (w_ent_rd),
        .o_ent_vld   (w_ent_vld)
    );

endmodule
